// File: rtl/multi_rate_tick_gen.sv
// Purpose : NUM_CH independent square-wave / tick generators sharing one clock, with
//           runtime-reloadable half-periods applied glitch-free at terminal count.
// Latency : outputs registered; sq_out/tick change on the edge where the counter hits half[i].
// Backpressure: one config request in flight; cfg_ready drops while an update is pending.
//
// Ports
//   clk_100MHz      : the only clock
//   reset           : asynchronous, active-low
//   enable          : per-channel run enable (low clears counter and outputs)
//   sync_clear      : synchronous realign of every channel
//   cfg_valid/ready : config handshake; cfg_ch selects channel, cfg_half_period is the new H
//   sq_out          : 50% duty square wave, period 2*(half+1)
//   tick            : one-cycle pulse coincident with each rising edge of sq_out
module multi_rate_tick_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int DEFAULT_HALF = 24_999_999,
    parameter int CH_W         = 2
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync_clear,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half_period,
    output logic [NUM_CH-1:0] sq_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
    // One extra bit so NUM_CH == 2**CH_W still compares correctly.
    localparam logic [CH_W:0]    NCH      = (CH_W+1)'(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } cfg_state_e;

    cfg_state_e state_q;
    logic             cfg_ready_q;
    logic [CH_W-1:0]  pend_ch_q;
    logic [CNT_W-1:0] pend_half_q;

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] half_q, half_d;
    logic [NUM_CH-1:0]            sq_q,   sq_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;

    logic [NUM_CH-1:0] term_w;
    logic [NUM_CH-1:0] apply_w;
    logic              apply_any;
    logic              cfg_in_range;

    assign cfg_in_range = ({1'b0, cfg_ch} < NCH);
    assign apply_any    = |apply_w;

    // Terminal count compares against the current (old) half, so the toggle in
    // the cycle an update lands still completes the old half-period.
    always_comb begin
        term_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            term_w[i] = enable[i] && (cnt_q[i] == half_q[i]);
        end
    end

    // A pending update lands when its channel reaches terminal count, is idle
    // (disabled), or is being realigned -- all points where cnt restarts at 0.
    always_comb begin
        apply_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_q == ST_PEND) && (pend_ch_q == CH_W'(i)) &&
                (sync_clear || !enable[i] || term_w[i])) begin
                apply_w[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        sq_d   = sq_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (apply_w[i]) begin
                half_d[i] = pend_half_q;
            end
            if (sync_clear || !enable[i]) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (term_w[i]) begin
                cnt_d[i]  = '0;
                sq_d[i]   = ~sq_q[i];
                tick_d[i] = ~sq_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            half_q <= {NUM_CH{DEF_HALF}};
            sq_q   <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
        end
    end

    // Config handshake. Out-of-range channels are accepted and dropped without
    // leaving IDLE, so the requester is never stalled by a bad index.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            pend_ch_q   <= '0;
            pend_half_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid && cfg_in_range) begin
                        pend_ch_q   <= cfg_ch;
                        pend_half_q <= cfg_half_period;
                        state_q     <= ST_PEND;
                        cfg_ready_q <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (apply_any) begin
                        state_q     <= ST_IDLE;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sq_out    = sq_q;
    assign tick      = tick_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Directed bench for multi_rate_tick_gen with DEFAULT_HALF=4 (period 10).
// A 4-channel instance carries most scenarios; a 3-channel instance covers
// the out-of-range config index.
module tb_multi_rate_tick_gen;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [3:0]  enable     = '0;
    logic        sync_clear = 1'b0;
    logic        cfg_valid  = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch     = '0;
    logic [26:0] cfg_half   = '0;
    logic [3:0]  sq_out;
    logic [3:0]  tick;

    logic [2:0]  enable3     = '0;
    logic        sync_clear3 = 1'b0;
    logic        cfg_valid3  = 1'b0;
    logic        cfg_ready3;
    logic [1:0]  cfg_ch3     = '0;
    logic [26:0] cfg_half3   = '0;
    logic [2:0]  sq_out3;
    logic [2:0]  tick3;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    multi_rate_tick_gen #(
        .NUM_CH(4), .CNT_W(27), .DEFAULT_HALF(4), .CH_W(2)
    ) u_dut (
        .clk_100MHz     (clk),
        .reset          (reset),
        .enable         (enable),
        .sync_clear     (sync_clear),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_ch         (cfg_ch),
        .cfg_half_period(cfg_half),
        .sq_out         (sq_out),
        .tick           (tick)
    );

    multi_rate_tick_gen #(
        .NUM_CH(3), .CNT_W(27), .DEFAULT_HALF(4), .CH_W(2)
    ) u_dut3 (
        .clk_100MHz     (clk),
        .reset          (reset),
        .enable         (enable3),
        .sync_clear     (sync_clear3),
        .cfg_valid      (cfg_valid3),
        .cfg_ready      (cfg_ready3),
        .cfg_ch         (cfg_ch3),
        .cfg_half_period(cfg_half3),
        .sq_out         (sq_out3),
        .tick           (tick3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready_async: got %b expected 1", cfg_ready);
        else pass_cnt++;
        repeat (3) step();
        chk_cnt++;
        if (sq_out !== 4'b0000) $display("FAIL reset_sq: got %b expected 0000", sq_out);
        else pass_cnt++;
        chk_cnt++;
        if (tick !== 4'b0000) $display("FAIL reset_tick: got %b expected 0000", tick);
        else pass_cnt++;
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        else pass_cnt++;
        chk_cnt++;
        if ({cfg_ready3, sq_out3, tick3} !== 7'b1000000)
            $display("FAIL reset_dut3: got %b expected 1000000", {cfg_ready3, sq_out3, tick3});
        else pass_cnt++;
    endtask

    // Release reset with only ch0 enabled: rise after 5 edges, period 10.
    task automatic test_ch0_period();
        logic [3:0] exp_sq, exp_tk;
        reset  = 1'b1;
        enable = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_sq = (((k / 5) % 2) == 1) ? 4'b0001 : 4'b0000;
            exp_tk = ((k % 10) == 5) ? 4'b0001 : 4'b0000;
            chk_cnt++;
            if (sq_out !== exp_sq) $display("FAIL ch0_sq k=%0d: got %b expected %b", k, sq_out, exp_sq);
            else pass_cnt++;
            chk_cnt++;
            if (tick !== exp_tk) $display("FAIL ch0_tick k=%0d: got %b expected %b", k, tick, exp_tk);
            else pass_cnt++;
        end
    endtask

    // ch1..3 reach terminal count exactly on the sync_clear edge: no toggle, no tick.
    task automatic test_sync_clear();
        repeat (3) step();
        enable = 4'b1111;
        repeat (4) step();
        chk_cnt++;
        if (sq_out !== 4'b0001) $display("FAIL sync_pre_sq: got %b expected 0001", sq_out);
        else pass_cnt++;
        sync_clear = 1'b1;
        step();
        sync_clear = 1'b0;
        chk_cnt++;
        if (sq_out !== 4'b0000) $display("FAIL sync_clr_sq: got %b expected 0000", sq_out);
        else pass_cnt++;
        chk_cnt++;
        if (tick !== 4'b0000) $display("FAIL sync_clr_tick: got %b expected 0000", tick);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_cnt++;
            if (sq_out !== 4'b0000) $display("FAIL sync_hold k=%0d: got %b expected 0000", k, sq_out);
            else pass_cnt++;
        end
        step();
        chk_cnt++;
        if (sq_out !== 4'b1111) $display("FAIL sync_rise_sq: got %b expected 1111", sq_out);
        else pass_cnt++;
        chk_cnt++;
        if (tick !== 4'b1111) $display("FAIL sync_rise_tick: got %b expected 1111", tick);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (tick !== 4'b0000) $display("FAIL sync_tick_drop: got %b expected 0000", tick);
        else pass_cnt++;
    endtask

    // ch1 H=1 while running: stays pending until ch1 terminal count (edge 5),
    // that toggle keeps the old half, then period 4.
    task automatic test_cfg_running();
        logic exp_sq, exp_tk, exp_rdy;
        sync_clear = 1'b1;
        enable     = 4'b0011;
        step();
        sync_clear = 1'b0;
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg1_idle_ready: got %b expected 1", cfg_ready);
        else pass_cnt++;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_half  = 27'd1;
        step();
        cfg_valid = 1'b0;
        chk_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL cfg1_accept_ready: got %b expected 0", cfg_ready);
        else pass_cnt++;
        for (int k = 2; k <= 14; k++) begin
            step();
            exp_rdy = (k >= 5);
            exp_sq  = (k >= 5) && ((((k - 5) / 2) % 2) == 0);
            exp_tk  = (k >= 5) && (((k - 5) % 4) == 0);
            chk_cnt++;
            if (cfg_ready !== exp_rdy) $display("FAIL cfg1_ready k=%0d: got %b expected %b", k, cfg_ready, exp_rdy);
            else pass_cnt++;
            chk_cnt++;
            if (sq_out[1] !== exp_sq) $display("FAIL cfg1_sq k=%0d: got %b expected %b", k, sq_out[1], exp_sq);
            else pass_cnt++;
            chk_cnt++;
            if (tick[1] !== exp_tk) $display("FAIL cfg1_tick k=%0d: got %b expected %b", k, tick[1], exp_tk);
            else pass_cnt++;
        end
    endtask

    // cfg_ch=3 on a 3-channel build: dropped, ready never falls, halves untouched.
    task automatic test_out_of_range();
        enable3     = 3'b111;
        sync_clear3 = 1'b1;
        cfg_valid3  = 1'b1;
        cfg_ch3     = 2'd3;
        cfg_half3   = 27'd1;
        step();
        sync_clear3 = 1'b0;
        chk_cnt++;
        if (cfg_ready3 !== 1'b1) $display("FAIL oob_ready1: got %b expected 1", cfg_ready3);
        else pass_cnt++;
        step();
        cfg_valid3 = 1'b0;
        chk_cnt++;
        if (cfg_ready3 !== 1'b1) $display("FAIL oob_ready2: got %b expected 1", cfg_ready3);
        else pass_cnt++;
        repeat (3) step();
        chk_cnt++;
        if (sq_out3 !== 3'b000) $display("FAIL oob_sq_hold: got %b expected 000", sq_out3);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (sq_out3 !== 3'b111) $display("FAIL oob_sq_rise: got %b expected 111", sq_out3);
        else pass_cnt++;
        chk_cnt++;
        if (tick3 !== 3'b111) $display("FAIL oob_tick_rise: got %b expected 111", tick3);
        else pass_cnt++;
    endtask

    // ch2 H=0 while disabled: applied on the next edge; then toggles every cycle.
    task automatic test_cfg_disabled();
        logic [3:0] exp_v;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_half  = 27'd0;
        step();
        cfg_valid = 1'b0;
        chk_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL cfg2_accept_ready: got %b expected 0", cfg_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg2_apply_ready: got %b expected 1", cfg_ready);
        else pass_cnt++;
        enable = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_v = ((k % 2) == 1) ? 4'b0100 : 4'b0000;
            chk_cnt++;
            if (sq_out !== exp_v) $display("FAIL cfg2_sq k=%0d: got %b expected %b", k, sq_out, exp_v);
            else pass_cnt++;
            chk_cnt++;
            if (tick !== exp_v) $display("FAIL cfg2_tick k=%0d: got %b expected %b", k, tick, exp_v);
            else pass_cnt++;
        end
    endtask

    // Reset while a ch1 update is pending: outputs clear without a clock edge,
    // and ch1 returns to the default period 10 afterwards.
    task automatic test_reset_mid_pend();
        logic [3:0] exp_sq, exp_tk;
        enable    = 4'b0110;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_half  = 27'd3;
        step();
        cfg_valid = 1'b0;
        chk_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL rst_pend_ready: got %b expected 0", cfg_ready);
        else pass_cnt++;
        chk_cnt++;
        if ({sq_out, tick} !== 8'b0100_0100) $display("FAIL rst_pre_out: got %b expected 01000100", {sq_out, tick});
        else pass_cnt++;
        reset = 1'b0;
        #2;
        chk_cnt++;
        if ({sq_out, tick} !== 8'b0000_0000) $display("FAIL rst_async_out: got %b expected 00000000", {sq_out, tick});
        else pass_cnt++;
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL rst_async_ready: got %b expected 1", cfg_ready);
        else pass_cnt++;
        step();
        step();
        reset  = 1'b1;
        enable = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_sq = (((k / 5) % 2) == 1) ? 4'b0010 : 4'b0000;
            exp_tk = ((k % 10) == 5) ? 4'b0010 : 4'b0000;
            chk_cnt++;
            if (sq_out !== exp_sq) $display("FAIL rst_ch1_sq k=%0d: got %b expected %b", k, sq_out, exp_sq);
            else pass_cnt++;
            chk_cnt++;
            if (tick !== exp_tk) $display("FAIL rst_ch1_tick k=%0d: got %b expected %b", k, tick, exp_tk);
            else pass_cnt++;
        end
        chk_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL rst_end_ready: got %b expected 1", cfg_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ch0_period();
        test_sync_clear();
        test_cfg_running();
        test_out_of_range();
        test_cfg_disabled();
        test_reset_mid_pend();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
